hazard_unit: RTL

Parametrised pipeline hazard controller for the five-stage core (F, D, E, M, WB). It sits beside the decode stage and tracks every in-flight register write in a private E/M/WB shadow pipeline. From that it produces the per-stage stall and flush controls, plus optional operand-forwarding selects. Beyond the RAW interlock, it handles:
- control-flow redirects,
- data-memory back-pressure,
- a forwarding mode with load-use interlock,
- saturating stall and flush event counters.

---
 rtl/hazard_unit.sv | 103 ++++++++++
 1 files changed

// File: rtl/hazard_unit.sv
// hazard_unit: five-stage pipeline hazard controller (RAW interlock, forwarding, redirect, back-pressure, event counters)
// Ports:
//   clk, reset                    clock and asynchronous active-high reset
//   id_valid/id_rd_en/id_rs1/id_rs2/id_we/id_rd/id_load   decode-stage instruction fields
//   redirect, mem_busy            taken control flow in E, data-memory back-pressure in M
//   stall_*/flush_*               per-stage hold and bubble controls (F, D, E, M, WB)
//   fwd_rs1/fwd_rs2               operand source: 00 regfile, 01 E, 10 M, 11 WB
//   raw_stall_cnt/redirect_cnt    saturating event counters
module hazard_unit #(
  parameter int AW       = 5,
  parameter int FWD_EN   = 0,
  parameter int ZERO_REG = 1,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             id_valid,
  input  logic [1:0]       id_rd_en,
  input  logic [AW-1:0]    id_rs1,
  input  logic [AW-1:0]    id_rs2,
  input  logic             id_we,
  input  logic [AW-1:0]    id_rd,
  input  logic             id_load,
  input  logic             redirect,
  input  logic             mem_busy,
  output logic             stall_F,
  output logic             stall_D,
  output logic             stall_E,
  output logic             stall_M,
  output logic             stall_WB,
  output logic             flush_F,
  output logic             flush_D,
  output logic             flush_E,
  output logic             flush_M,
  output logic             flush_WB,
  output logic [1:0]       fwd_rs1,
  output logic [1:0]       fwd_rs2,
  output logic [CNT_W-1:0] raw_stall_cnt,
  output logic [CNT_W-1:0] redirect_cnt
);
  typedef struct packed {
    logic          v;
    logic          we;
    logic [AW-1:0] rd;
    logic          load;
  } ent_t;
  localparam logic [CNT_W-1:0] cnt_one = 1;
  ent_t e, m, wb;
  logic rd1, rd2, s1e, s1m, s1w, s2e, s2m, s2w, raw, hz, redir;
  logic unused;
  assign unused = wb.load;
  function automatic logic live(ent_t x);
    return x.v && x.we && !(ZERO_REG != 0 && x.rd == '0);
  endfunction
  always_comb begin
    rd1   = id_valid && id_rd_en[0];
    rd2   = id_valid && id_rd_en[1];
    s1e   = rd1 && live(e)  && e.rd  == id_rs1;
    s1m   = rd1 && live(m)  && m.rd  == id_rs1;
    s1w   = rd1 && live(wb) && wb.rd == id_rs1;
    s2e   = rd2 && live(e)  && e.rd  == id_rs2;
    s2m   = rd2 && live(m)  && m.rd  == id_rs2;
    s2w   = rd2 && live(wb) && wb.rd == id_rs2;
    // with forwarding only a load still in E cannot supply its result in time
    raw   = FWD_EN != 0 ? (s1e || s2e) && e.load : s1e || s1m || s1w || s2e || s2m || s2w;
    redir = !mem_busy && redirect;
    hz    = !mem_busy && !redirect && raw;
  end
  assign stall_F  = !reset && (mem_busy || hz);
  assign stall_D  = !reset && (mem_busy || hz);
  assign stall_E  = !reset && mem_busy;
  assign stall_M  = !reset && mem_busy;
  assign stall_WB = 1'b0;
  assign flush_F  = reset;
  assign flush_D  = reset || redir;
  assign flush_E  = reset || redir || hz;
  assign flush_M  = reset;
  assign flush_WB = reset || mem_busy;
  assign fwd_rs1  = (reset || FWD_EN == 0) ? 2'b00 : s1e ? 2'b01 : s1m ? 2'b10 : s1w ? 2'b11 : 2'b00;
  assign fwd_rs2  = (reset || FWD_EN == 0) ? 2'b00 : s2e ? 2'b01 : s2m ? 2'b10 : s2w ? 2'b11 : 2'b00;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      e  <= '0;
      m  <= '0;
      wb <= '0;
    end else if (mem_busy) begin
      wb.v <= 1'b0;
    end else begin
      e  <= '{v: id_valid && !(redir || hz), we: id_we, rd: id_rd, load: id_load};
      m  <= e;
      wb <= m;
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      raw_stall_cnt <= '0;
      redirect_cnt  <= '0;
    end else begin
      if (hz && !(&raw_stall_cnt)) raw_stall_cnt <= raw_stall_cnt + cnt_one;
      if (redir && !(&redirect_cnt)) redirect_cnt <= redirect_cnt + cnt_one;
    end
  end
endmodule
